aoi_bist_seq: RTL
=================

Name: aoi_bist_seq

Overview:
Built-in self-test sequencer for the 4-input and-or-invert cell y = ~((a&b)|(c&d)). It sits directly upstream of the AOI cell and drives its a, b, c, d inputs through all 16 vectors, 0000 to 1111. It samples the cell's y output back, compares it with the expected value and reports the mismatch count, the first failing vector and pass/fail. It replaces the hand-written exhaustive sweep used for the cell today.

Parameters:
DWELL, 10, clock cycles each vector is held before y is sampled; legal range 1..255.
ERR_W, 5, width of the mismatch counter; the counter saturates at 2^ERR_W-1.

Ports:
clk  in  1  clock; rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request a test run; sampled only in IDLE.
y  in  1  output of the AOI cell under test.
a  out  1  AOI input a; bit 3 of the current vector.
b  out  1  AOI input b; bit 2 of the current vector.
c  out  1  AOI input c; bit 1 of the current vector.
d  out  1  AOI input d; bit 0 of the current vector.
vec  out  4  index of the vector currently applied.
busy  out  1  high while a run is in progress.
done  out  1  one-cycle pulse at the end of a run.
pass  out  1  high when the last completed run had zero mismatches.
err_cnt  out  ERR_W  mismatches counted in the current or last run.
fail_vec  out  4  vector index of the first mismatch; meaningful only when err_cnt != 0.

Behaviour:
- Clocking and reset
  - Single clock domain; all outputs are registered.
  - rst is synchronous and active-high and takes priority over everything else.
  - On reset: state=IDLE, {a,b,c,d}=0000, vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
- Output relations
  - {a,b,c,d} equals vec at all times.
  - Expected value: exp = ~((vec[3]&vec[2])|(vec[1]&vec[0])).
- Dwell counter
  - dcnt counts 0..DWELL-1 and is internal.
- State IDLE
  - busy=0.
  - If start=1 at an edge: next state RUN, vec=0, dcnt=0, err_cnt=0, fail_vec=0, pass=0, busy=1.
  - If start=0: all outputs hold.
- State RUN
  - vec is held while dcnt < DWELL-1; dcnt increments each cycle.
  - At the edge where dcnt==DWELL-1, y is sampled.
  - If y != exp:
    - err_cnt increments, saturating at 2^ERR_W-1.
    - If err_cnt was 0 before this increment, fail_vec latches vec.
  - Then, if vec==15, next state is DONE; otherwise vec increments and dcnt returns to 0.
- State DONE (exactly one cycle)
  - done=1, busy=0, pass=(err_cnt==0).
  - vec stays at 15.
  - Next state IDLE.
- Timing
  - With start accepted at edge 0, RUN occupies cycles 1..16*DWELL.
  - done is high in cycle 16*DWELL+1.
  - Total run latency is 16*DWELL+1 cycles.
- start handling
  - start is ignored in RUN and in DONE; it is not queued.
  - start held high continuously triggers back-to-back runs, one IDLE cycle apart.
- Result persistence
  - pass, err_cnt and fail_vec hold after DONE until the next accepted start or reset.
- Reset mid-run
  - The run is aborted and all outputs take their reset values on the next cycle.
  - No done pulse is produced.
- DWELL=1
  - Each vector is applied for one cycle and y is sampled at the end of that same cycle.
- Timing assumption
  - The AOI cell is combinational and settles within one cycle.

Test Plan:
1. Good AOI, DWELL=10, start pulse at cycle 0 -> vectors 0000..1111 each held 10 cycles; busy high for cycles 1..160; done=1 in cycle 161; pass=1, err_cnt=0.
2. y tied 0, DWELL=10 -> err_cnt=9, fail_vec=0000, pass=0 after done.
3. y tied 1, DWELL=2 -> err_cnt=7, fail_vec=0011 (3), pass=0; done in cycle 33.
4. y driven as the inverse of a good AOI, ERR_W=3 -> err_cnt saturates at 7, fail_vec=0, pass=0.
5. rst asserted while vec=5 -> next cycle vec=0, busy=0, err_cnt=0, no done pulse. A new start then restarts the sweep from 0000 and completes normally.
6. start pulsed again at vec=8 mid-run, DWELL=1 -> ignored; done in cycle 17 only. start held high -> a second run begins one cycle after done.

Source files
------------

// File: rtl/aoi_bist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aoi_bist_seq
//  Description : Built-in self-test sequencer for a 4-input and-or-invert cell
//                y = ~((a&b)|(c&d)). Sweeps the cell inputs through all 16
//                vectors and holds each one for DWELL cycles. On the last
//                cycle of each vector it samples y and compares it with the
//                expected value. It reports a saturating mismatch count, the
//                first failing vector and a pass flag.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-high reset
//                start    - run request, sampled only while idle
//                y        - AOI cell output under test
//                a,b,c,d  - AOI cell inputs (vec[3:0])
//                vec      - index of the vector currently applied
//                busy     - high while a run is in progress
//                done     - one-cycle pulse at the end of a run
//                pass     - last completed run had zero mismatches
//                err_cnt  - mismatches in the current or last run (saturating)
//                fail_vec - vector index of the first mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module aoi_bist_seq #(
    parameter int DWELL = 10,   // cycles per vector, 1..255
    parameter int ERR_W = 5     // mismatch counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic [3:0]       vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    // A one-bit dwell counter is kept even for DWELL=1. It then stays at 0,
    // so every cycle is a sample cycle.
    localparam int                c_DCNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DWELL - 1);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;
    localparam logic [3:0]          c_VEC_LAST  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_vec;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [ERR_W-1:0]    r_err_cnt;
    logic [3:0]          r_fail_vec;

    logic             w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // Expected cell response for the vector currently on the inputs.
    assign w_exp      = ~((r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]));
    assign w_mismatch = (y != w_exp);

    // Count value after this sample. pass is computed from this value so that
    // a mismatch on the final vector still clears pass.
    always_comb begin
        w_err_next = r_err_cnt;
        if (w_mismatch && (r_err_cnt != c_ERR_MAX)) begin
            w_err_next = r_err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vec      <= 4'd0;
            r_dcnt     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vec <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_vec      <= 4'd0;
                        r_dcnt     <= '0;
                        r_err_cnt  <= '0;
                        r_fail_vec <= 4'd0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (r_dcnt == c_DCNT_LAST) begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && (r_err_cnt == '0)) begin
                            r_fail_vec <= r_vec;
                        end
                        if (r_vec == c_VEC_LAST) begin
                            // Vector 15 stays applied through DONE.
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_vec  <= r_vec + 4'd1;
                            r_dcnt <= '0;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + c_DCNT_W'(1);
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a        = r_vec[3];
    assign b        = r_vec[2];
    assign c        = r_vec[1];
    assign d        = r_vec[0];
    assign vec      = r_vec;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

endmodule
`default_nettype wire
